ifu_fetch: RTL and testbench

- Instruction fetch stage of the NPC core; sits directly upstream of the decode stage.
- Holds the PC and issues single-beat instruction reads on an AXI4-Lite-style read channel.
- Generates the sign-extended immediate and presents {inst, imm, pc, exception, mcause} to decode under a valid/ready handshake.
- Accepts redirects (branch, jump, trap, mret) from later stages.

---
 rtl/ifu_fetch_pkg.sv | 33 +++
 rtl/ifu_fetch_if.sv | 47 ++++
 rtl/ifu_immgen.sv | 37 +++
 rtl/ifu_fetch.sv | 180 ++++++++++++++++++
 tb/tb_ifu_fetch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared definitions for the NPC instruction fetch stage: RISC-V opcode
// constants used by the immediate generator, the fetch FSM state type,
// the machine-cause codes a fetch can raise, and a small alignment helper.
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [3:0] MCAUSE_IMISALIGN = 4'd0;
   localparam logic [3:0] MCAUSE_IFAULT    = 4'd1;

   typedef enum logic [1:0] {
      ADDR = 2'd0,
      DATA = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   // Instructions are 32-bit words, so only the two low PC bits matter.
   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return low_bits == 2'b00;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
// Bundles everything the fetch stage exchanges with the outside world:
//   - AXI4-Lite-style read address / read data channels to memory
//   - redirect request from later pipeline stages
//   - fetch packet and valid/ready handshake towards decode
// Signal prefixes (o_/i_) are from the point of view of the fetch unit.
// Modports:
//   master : the fetch unit itself
//   slave  : memory / decode / redirect environment
// ---------------------------------------------------------------------------
interface ifu_fetch_if;

   logic [31:0] o_araddr;
   logic        o_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        i_rvalid;
   logic        o_rready;

   logic        i_redirect;
   logic [31:0] i_redirect_pc;

   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_inst;
   logic [31:0] o_imm;
   logic [31:0] o_pc;
   logic        o_exception;
   logic [3:0]  o_mcause;

   modport master (
      output o_araddr, o_arvalid, o_rready,
      output o_valid, o_inst, o_imm, o_pc, o_exception, o_mcause,
      input  i_arready, i_rdata, i_rresp, i_rvalid,
      input  i_redirect, i_redirect_pc, i_ready
   );

   modport slave (
      input  o_araddr, o_arvalid, o_rready,
      input  o_valid, o_inst, o_imm, o_pc, o_exception, o_mcause,
      output i_arready, i_rdata, i_rresp, i_rvalid,
      output i_redirect, i_redirect_pc, i_ready
   );

endinterface

// File: rtl/ifu_immgen.sv
// ---------------------------------------------------------------------------
// ifu_immgen
// Purely combinational RV32I immediate generator.
// Ports:
//   inst : 32-bit instruction word
//   imm  : sign-extended (or upper) immediate selected by inst[6:0];
//          zero for opcodes that carry no immediate
// ---------------------------------------------------------------------------
module ifu_immgen
   import ifu_fetch_pkg::*;
(
   input  logic [31:0] inst,
   output logic [31:0] imm
);

   // Reassemble the scattered immediate fields for each instruction format.
   // B and J formats have an implicit zero LSB because targets are
   // halfword-granular.
   always_comb begin
      imm = '0;
      case (inst[6:0])
         OP_I, OP_L, OP_JALR, OP_SYS:
            imm = {{20{inst[31]}}, inst[31:20]};
         OP_S:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OP_B:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {inst[31:12], 12'b0};
         OP_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage of the NPC core. Holds the PC, issues one
// single-beat read at a time, and hands {inst, imm, pc, exception, mcause}
// to decode under a valid/ready handshake. Later stages can redirect the
// PC at any time; a read already on the bus is allowed to finish and its
// data is thrown away.
// Parameters:
//   RESET_PC : first PC fetched after reset
//   NOP_INST : instruction word presented when a fetch faults
// Ports:
//   i_clock  : clock
//   i_reset  : asynchronous, active-high reset
//   bus      : ifu_fetch_if.master (read channel, redirect, decode packet)
// ---------------------------------------------------------------------------
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_clock,
   input  logic        i_reset,
   ifu_fetch_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         drop_q, drop_d;
   logic         arvalid_q, arvalid_d;
   logic [31:0]  araddr_q, araddr_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  imm_q, imm_d;
   logic         exc_q, exc_d;
   logic [3:0]   mcause_q, mcause_d;

   logic [31:0]  rdata_imm;
   logic [31:0]  target_pc;
   logic         enter_addr;
   logic [31:0]  enter_pc;

   ifu_immgen u_immgen (
      .inst (bus.i_rdata),
      .imm  (rdata_imm)
   );

   // A same-cycle redirect always overrides the PC we would otherwise use.
   assign target_pc = bus.i_redirect ? bus.i_redirect_pc : pc_q;

   // Next-state logic. The address channel is registered so that araddr
   // stays put while arvalid waits for arready, even if a redirect moves
   // the PC underneath it. Every path back into ADDR issues the request on
   // the same edge (enter_addr), which keeps fetch latency at two cycles;
   // a misaligned target enters ADDR without a request and is turned into
   // an exception packet on the following edge.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      arvalid_d  = arvalid_q;
      araddr_d   = araddr_q;
      inst_d     = inst_q;
      imm_d      = imm_q;
      exc_d      = exc_q;
      mcause_d   = mcause_q;
      enter_addr = 1'b0;
      enter_pc   = pc_q;

      case (state_q)
         ADDR: begin
            if (arvalid_q) begin
               if (bus.i_redirect) begin
                  pc_d   = bus.i_redirect_pc;
                  drop_d = 1'b1;
               end
               if (bus.i_arready) begin
                  arvalid_d = 1'b0;
                  state_d   = DATA;
               end
            end else if (!is_word_aligned(target_pc[1:0])) begin
               pc_d     = target_pc;
               inst_d   = NOP_INST;
               imm_d    = '0;
               exc_d    = 1'b1;
               mcause_d = MCAUSE_IMISALIGN;
               state_d  = HOLD;
            end else begin
               pc_d      = target_pc;
               arvalid_d = 1'b1;
               araddr_d  = target_pc;
            end
         end

         DATA: begin
            if (bus.i_redirect) begin
               pc_d = bus.i_redirect_pc;
            end
            if (bus.i_rvalid) begin
               if (drop_q || bus.i_redirect) begin
                  drop_d     = 1'b0;
                  enter_addr = 1'b1;
                  enter_pc   = target_pc;
               end else if (bus.i_rresp != 2'b00) begin
                  inst_d   = NOP_INST;
                  imm_d    = '0;
                  exc_d    = 1'b1;
                  mcause_d = MCAUSE_IFAULT;
                  state_d  = HOLD;
               end else begin
                  inst_d   = bus.i_rdata;
                  imm_d    = rdata_imm;
                  exc_d    = 1'b0;
                  mcause_d = '0;
                  state_d  = HOLD;
               end
            end else if (bus.i_redirect) begin
               drop_d = 1'b1;
            end
         end

         HOLD: begin
            if (bus.i_redirect) begin
               enter_addr = 1'b1;
               enter_pc   = bus.i_redirect_pc;
            end else if (bus.i_ready) begin
               enter_addr = 1'b1;
               enter_pc   = pc_q + 32'd4;
            end
         end

         default: begin
            state_d = ADDR;
         end
      endcase

      if (enter_addr) begin
         state_d   = ADDR;
         pc_d      = enter_pc;
         arvalid_d = is_word_aligned(enter_pc[1:0]);
         araddr_d  = enter_pc;
      end
   end

   // State register. Reset parks the FSM in ADDR with no request pending;
   // the first request goes out on the first edge after reset is released.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ADDR;
         pc_q      <= RESET_PC;
         drop_q    <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= RESET_PC;
         inst_q    <= NOP_INST;
         imm_q     <= '0;
         exc_q     <= 1'b0;
         mcause_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         inst_q    <= inst_d;
         imm_q     <= imm_d;
         exc_q     <= exc_d;
         mcause_q  <= mcause_d;
      end
   end

   assign bus.o_araddr    = araddr_q;
   assign bus.o_arvalid   = arvalid_q;
   assign bus.o_rready    = (state_q == DATA);
   assign bus.o_valid     = (state_q == HOLD);
   assign bus.o_inst      = inst_q;
   assign bus.o_imm       = imm_q;
   assign bus.o_pc        = pc_q;
   assign bus.o_exception = exc_q;
   assign bus.o_mcause    = mcause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
// Directed testbench for ifu_fetch. Plays memory, decode and the redirect
// source through an ifu_fetch_if instance. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   ifu_fetch_if bus ();

   ifu_fetch #(
      .RESET_PC (32'h8000_0000),
      .NOP_INST (NOP)
   ) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n clock edges and step just past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_arvalid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_arvalid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic wait_valid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic ar_accept();
      bus.i_arready = 1'b1;
      cyc(1);
      bus.i_arready = 1'b0;
   endtask

   task automatic r_send(input logic [31:0] data, input logic [1:0] resp);
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = data;
      bus.i_rresp  = resp;
      cyc(1);
      bus.i_rvalid = 1'b0;
      bus.i_rresp  = 2'b00;
   endtask

   task automatic accept();
      bus.i_ready = 1'b1;
      cyc(1);
      bus.i_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = target;
      cyc(1);
      bus.i_redirect    = 1'b0;
   endtask

   // Reset values, then the first request right after release.
   task automatic test_reset();
      $display("[TB] test_reset");
      reset = 1'b1;
      cyc(2);
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b0 || bus.o_rready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: valid/arvalid/rready got %b%b%b expected 000",
                  bus.o_valid, bus.o_arvalid, bus.o_rready);
      end
      vectors++;
      if (bus.o_inst !== NOP || bus.o_imm !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_pkt: inst %h imm %h expected %h 00000000", bus.o_inst, bus.o_imm, NOP);
      end
      vectors++;
      if (bus.o_exception !== 1'b0 || bus.o_mcause !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_exc: exc %b mcause %0d expected 0 0", bus.o_exception, bus.o_mcause);
      end
      reset = 1'b0;
      vectors++;
      if (bus.o_arvalid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL release_arvalid: got %b expected 0", bus.o_arvalid);
      end
      cyc(1);
      vectors++;
      if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0000) begin
         miscompares++;
         $display("[TB] FAIL first_req: arvalid %b araddr %h expected 1 80000000", bus.o_arvalid, bus.o_araddr);
      end
   endtask

   // addi x1, x0, 5 at the reset PC.
   task automatic test_basic_fetch();
      bit seen;
      $display("[TB] test_basic_fetch");
      wait_arvalid(seen);
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL basic_arvalid_timeout: got 0 expected 1");
      end
      ar_accept();
      vectors++;
      if (bus.o_rready !== 1'b1 || bus.o_arvalid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_data_state: rready %b arvalid %b expected 1 0", bus.o_rready, bus.o_arvalid);
      end
      r_send(32'h0050_0093, 2'b00);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_inst !== 32'h0050_0093 || bus.o_imm !== 32'h5 ||
          bus.o_pc !== 32'h8000_0000 || bus.o_exception !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_packet: valid %b inst %h imm %h pc %h exc %b expected 1 00500093 00000005 80000000 0",
                  bus.o_valid, bus.o_inst, bus.o_imm, bus.o_pc, bus.o_exception);
      end
      accept();
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0004) begin
         miscompares++;
         $display("[TB] FAIL basic_next_req: valid %b arvalid %b araddr %h expected 0 1 80000004",
                  bus.o_valid, bus.o_arvalid, bus.o_araddr);
      end
   endtask

   // Decode stalls for five cycles: packet must not move, no new request.
   task automatic test_stall();
      $display("[TB] test_stall");
      ar_accept();
      r_send(32'h0020_8033, 2'b00);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.o_valid !== 1'b1 || bus.o_inst !== 32'h0020_8033 || bus.o_imm !== 32'h0 ||
             bus.o_pc !== 32'h8000_0004 || bus.o_arvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold[%0d]: valid %b inst %h imm %h pc %h arvalid %b expected 1 00208033 00000000 80000004 0",
                     i, bus.o_valid, bus.o_inst, bus.o_imm, bus.o_pc, bus.o_arvalid);
         end
         cyc(1);
      end
      accept();
      vectors++;
      if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0008) begin
         miscompares++;
         $display("[TB] FAIL stall_advance: arvalid %b araddr %h expected 1 80000008", bus.o_arvalid, bus.o_araddr);
      end
   endtask

   // Error response becomes an access-fault packet carrying a NOP.
   task automatic test_fault();
      $display("[TB] test_fault");
      ar_accept();
      r_send(32'h1234_5037, 2'b10);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_exception !== 1'b1 || bus.o_mcause !== 4'd1 ||
          bus.o_pc !== 32'h8000_0008 || bus.o_inst !== NOP || bus.o_imm !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL fault_packet: valid %b exc %b mcause %0d pc %h inst %h imm %h expected 1 1 1 80000008 %h 00000000",
                  bus.o_valid, bus.o_exception, bus.o_mcause, bus.o_pc, bus.o_inst, bus.o_imm, NOP);
      end
      accept();
      vectors++;
      if (bus.o_araddr !== 32'h8000_000c) begin
         miscompares++;
         $display("[TB] FAIL fault_next_req: araddr %h expected 8000000c", bus.o_araddr);
      end
   endtask

   // Redirect while waiting for data: stale word is dropped.
   task automatic test_redirect_data();
      $display("[TB] test_redirect_data");
      ar_accept();
      redirect(32'h8000_0100);
      vectors++;
      if (bus.o_rready !== 1'b1 || bus.o_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL redir_data_wait: rready %b valid %b expected 1 0", bus.o_rready, bus.o_valid);
      end
      r_send(32'hdead_beef, 2'b00);
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0100) begin
         miscompares++;
         $display("[TB] FAIL redir_data_refetch: valid %b arvalid %b araddr %h expected 0 1 80000100",
                  bus.o_valid, bus.o_arvalid, bus.o_araddr);
      end
      cyc(2);
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_inst !== NOP) begin
         miscompares++;
         $display("[TB] FAIL redir_data_discard: valid %b inst %h expected 0 %h", bus.o_valid, bus.o_inst, NOP);
      end
      ar_accept();
      r_send(32'h8000_00ef, 2'b00);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_imm !== 32'hfff0_0000 || bus.o_pc !== 32'h8000_0100) begin
         miscompares++;
         $display("[TB] FAIL redir_jal: valid %b imm %h pc %h expected 1 fff00000 80000100",
                  bus.o_valid, bus.o_imm, bus.o_pc);
      end
      accept();
   endtask

   // Redirect to a misaligned PC while a request waits for arready.
   task automatic test_redirect_misaligned();
      bit seen;
      $display("[TB] test_redirect_misaligned");
      redirect(32'h8000_0102);
      cyc(2);
      vectors++;
      if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0104) begin
         miscompares++;
         $display("[TB] FAIL ar_stable: arvalid %b araddr %h expected 1 80000104", bus.o_arvalid, bus.o_araddr);
      end
      ar_accept();
      r_send(32'h0050_0093, 2'b00);
      vectors++;
      if (bus.o_arvalid !== 1'b0 || bus.o_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL misalign_noreq: arvalid %b valid %b expected 0 0", bus.o_arvalid, bus.o_valid);
      end
      wait_valid(seen);
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL misalign_valid_timeout: got 0 expected 1");
      end
      vectors++;
      if (bus.o_exception !== 1'b1 || bus.o_mcause !== 4'd0 || bus.o_inst !== NOP ||
          bus.o_pc !== 32'h8000_0102 || bus.o_arvalid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL misalign_packet: exc %b mcause %0d inst %h pc %h arvalid %b expected 1 0 %h 80000102 0",
                  bus.o_exception, bus.o_mcause, bus.o_inst, bus.o_pc, bus.o_arvalid, NOP);
      end
      // Redirect and decode acceptance in the same cycle: redirect wins.
      bus.i_ready = 1'b1;
      redirect(32'h8000_0200);
      bus.i_ready = 1'b0;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0200) begin
         miscompares++;
         $display("[TB] FAIL redir_beats_ready: valid %b arvalid %b araddr %h expected 0 1 80000200",
                  bus.o_valid, bus.o_arvalid, bus.o_araddr);
      end
   endtask

   // Immediate formats through the full fetch path.
   task automatic test_immgen();
      logic [31:0] insts [4];
      logic [31:0] imms  [4];
      insts = '{32'hfe00_0ee3, 32'h1234_5037, 32'hfe11_2e23, 32'h0020_8033};
      imms  = '{32'hffff_fffc, 32'h1234_5000, 32'hffff_fffc, 32'h0000_0000};
      $display("[TB] test_immgen");
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (bus.o_araddr !== 32'h8000_0200 + 32'(4 * k)) begin
            miscompares++;
            $display("[TB] FAIL imm_addr[%0d]: araddr %h expected %h", k, bus.o_araddr, 32'h8000_0200 + 32'(4 * k));
         end
         ar_accept();
         r_send(insts[k], 2'b00);
         vectors++;
         if (bus.o_valid !== 1'b1 || bus.o_inst !== insts[k] || bus.o_imm !== imms[k]) begin
            miscompares++;
            $display("[TB] FAIL imm[%0d]: valid %b inst %h imm %h expected 1 %h %h",
                     k, bus.o_valid, bus.o_inst, bus.o_imm, insts[k], imms[k]);
         end
         accept();
      end
   endtask

   // Redirect arriving together with the read data.
   task automatic test_redirect_rvalid();
      $display("[TB] test_redirect_rvalid");
      ar_accept();
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = 32'h0050_0093;
      redirect(32'h8000_0300);
      bus.i_rvalid = 1'b0;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0300) begin
         miscompares++;
         $display("[TB] FAIL redir_rvalid: valid %b arvalid %b araddr %h expected 0 1 80000300",
                  bus.o_valid, bus.o_arvalid, bus.o_araddr);
      end
   endtask

   // Reset in DATA, late rvalid afterwards must be ignored.
   task automatic test_reset_midflight();
      $display("[TB] test_reset_midflight");
      ar_accept();
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.o_rready !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_arvalid !== 1'b0 || bus.o_inst !== NOP) begin
         miscompares++;
         $display("[TB] FAIL midreset_async: rready %b valid %b arvalid %b inst %h expected 0 0 0 %h",
                  bus.o_rready, bus.o_valid, bus.o_arvalid, bus.o_inst, NOP);
      end
      cyc(1);
      reset        = 1'b0;
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = 32'h8000_00ef;
      cyc(1);
      bus.i_rvalid = 1'b0;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_rready !== 1'b0 || bus.o_arvalid !== 1'b1 ||
          bus.o_araddr !== 32'h8000_0000) begin
         miscompares++;
         $display("[TB] FAIL midreset_late_rvalid: valid %b rready %b arvalid %b araddr %h expected 0 0 1 80000000",
                  bus.o_valid, bus.o_rready, bus.o_arvalid, bus.o_araddr);
      end
      ar_accept();
      r_send(32'h0050_0093, 2'b00);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h8000_0000 || bus.o_imm !== 32'h5) begin
         miscompares++;
         $display("[TB] FAIL midreset_refetch: valid %b pc %h imm %h expected 1 80000000 00000005",
                  bus.o_valid, bus.o_pc, bus.o_imm);
      end
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      reset             = 1'b1;
      bus.i_arready     = 1'b0;
      bus.i_rdata       = '0;
      bus.i_rresp       = 2'b00;
      bus.i_rvalid      = 1'b0;
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_ready       = 1'b0;
      #1;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_fault();
      test_redirect_data();
      test_redirect_misaligned();
      test_immgen();
      test_redirect_rvalid();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
